// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: seconds/minutes/hours counters driven by a 1 Hz enable,
// plus the run / set-hours / set-minutes state machine for user time setting.
module clock_time_ctrl #(
  parameter int unsigned HOURS_MAX = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_wrap
);

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MS_W   = 6;
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_MAX - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(59);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [HOUR_W-1:0] hours_nxt;
  logic [MS_W-1:0]   minutes_nxt, seconds_nxt;
  logic              blink_nxt, day_wrap_nxt;

  // Wrap detection: the last legal value or anything beyond it reloads zero.
  logic sec_wrap, min_wrap, hr_wrap;
  logic sec_last, min_last, hr_last;
  assign sec_last = (seconds == MS_LAST);
  assign min_last = (minutes == MS_LAST);
  assign hr_last  = (hours == HOUR_LAST);
  assign sec_wrap = (seconds >= MS_LAST);
  assign min_wrap = (minutes >= MS_LAST);
  assign hr_wrap  = (hours >= HOUR_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      blink    <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      state    <= state_nxt;
      hours    <= hours_nxt;
      minutes  <= minutes_nxt;
      seconds  <= seconds_nxt;
      blink    <= blink_nxt;
      day_wrap <= day_wrap_nxt;
    end
  end

  assign mode = state;

  // Next-state and next-time decode; all actions keyed on the current state.
  always_comb begin
    state_nxt    = state;
    hours_nxt    = hours;
    minutes_nxt  = minutes;
    seconds_nxt  = seconds;
    blink_nxt    = blink;
    day_wrap_nxt = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (tick_1hz) begin
          seconds_nxt = sec_wrap ? '0 : seconds + MS_W'(1);
          if (sec_last) begin
            minutes_nxt = min_wrap ? '0 : minutes + MS_W'(1);
            if (min_last) begin
              hours_nxt = hr_wrap ? '0 : hours + HOUR_W'(1);
              day_wrap_nxt = hr_last;
            end
          end
        end
        if (mode_btn) begin
          state_nxt = ST_SET_HR;
          blink_nxt = 1'b1;
        end
      end
      ST_SET_HR: begin
        if (inc_btn)  hours_nxt = hr_wrap ? '0 : hours + HOUR_W'(1);
        if (tick_1hz) blink_nxt = ~blink;
        if (mode_btn) begin
          state_nxt = ST_SET_MIN;
          blink_nxt = 1'b1;
        end
      end
      ST_SET_MIN: begin
        if (inc_btn)  minutes_nxt = min_wrap ? '0 : minutes + MS_W'(1);
        if (tick_1hz) blink_nxt = ~blink;
        if (mode_btn) begin
          state_nxt   = ST_RUN;
          seconds_nxt = '0;
          blink_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        blink_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl in 24-hour and 12-hour builds.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_a, mode_a, inc_a;
  logic       tick_b, mode_b, inc_b;
  logic [4:0] hours_a, hours_b;
  logic [5:0] minutes_a, minutes_b, seconds_a, seconds_b;
  logic [1:0] mode_o_a, mode_o_b;
  logic       blink_a, blink_b, day_wrap_a, day_wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_time_ctrl #(.HOURS_MAX(24)) dut24 (
    .clk(clk), .reset(reset), .tick_1hz(tick_a), .mode_btn(mode_a), .inc_btn(inc_a),
    .hours(hours_a), .minutes(minutes_a), .seconds(seconds_a), .mode(mode_o_a),
    .blink(blink_a), .day_wrap(day_wrap_a)
  );

  clock_time_ctrl #(.HOURS_MAX(12)) dut12 (
    .clk(clk), .reset(reset), .tick_1hz(tick_b), .mode_btn(mode_b), .inc_btn(inc_b),
    .hours(hours_b), .minutes(minutes_b), .seconds(seconds_b), .mode(mode_o_b),
    .blink(blink_b), .day_wrap(day_wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses on the selected instance (0 = 24h, 1 = 12h).
  task automatic step(input bit sel, input bit t, input bit m, input bit i);
    if (sel) begin tick_b = t; mode_b = m; inc_b = i; end
    else     begin tick_a = t; mode_a = m; inc_a = i; end
    @(posedge clk);
    #1;
    tick_a = 0; mode_a = 0; inc_a = 0;
    tick_b = 0; mode_b = 0; inc_b = 0;
  endtask

  task automatic rep(input bit sel, input int n, input bit t, input bit i);
    for (int k = 0; k < n; k++) step(sel, t, 1'b0, i);
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hours"},   32'(hours_a),   32'(h));
    chk({tag, ".minutes"}, 32'(minutes_a), 32'(m));
    chk({tag, ".seconds"}, 32'(seconds_a), 32'(s));
  endtask

  initial begin
    reset = 1; tick_a = 0; mode_a = 0; inc_a = 0; tick_b = 0; mode_b = 0; inc_b = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk_time("rst", 0, 0, 0);
    chk("rst.mode", 32'(mode_o_a), 0);
    chk("rst.blink", 32'(blink_a), 0);
    chk("rst.day_wrap", 32'(day_wrap_a), 0);

    // Reset in the middle of SET_MIN
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    rep(0, 37, 0, 1);
    chk("setmin.minutes", 32'(minutes_a), 37);
    chk("setmin.mode", 32'(mode_o_a), 2);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk_time("rst2", 0, 0, 0);
    chk("rst2.mode", 32'(mode_o_a), 0);
    chk("rst2.blink", 32'(blink_a), 0);
    chk("rst2.day_wrap", 32'(day_wrap_a), 0);

    // Preload 23:59, exit set mode, count up to the day rollover
    step(0, 0, 1, 0);
    rep(0, 23, 0, 1);
    step(0, 0, 1, 0);
    rep(0, 59, 0, 1);
    step(0, 0, 1, 0);
    chk_time("pre", 23, 59, 0);
    chk("pre.mode", 32'(mode_o_a), 0);
    chk("pre.blink", 32'(blink_a), 0);
    rep(0, 58, 1, 0);
    chk_time("t58", 23, 59, 58);
    step(0, 1, 0, 0);
    chk_time("t59", 23, 59, 59);
    chk("t59.day_wrap", 32'(day_wrap_a), 0);
    step(0, 1, 0, 0);
    chk_time("wrap", 0, 0, 0);
    chk("wrap.day_wrap", 32'(day_wrap_a), 1);
    step(0, 0, 0, 0);
    chk("wrap+1.day_wrap", 32'(day_wrap_a), 0);

    // Set 10:20, count to :45, then edit to 13:05
    step(0, 0, 1, 0);
    rep(0, 10, 0, 1);
    step(0, 0, 1, 0);
    rep(0, 20, 0, 1);
    step(0, 0, 1, 0);
    rep(0, 45, 1, 0);
    chk_time("t1020", 10, 20, 45);
    step(0, 0, 1, 0);
    chk("sethr.mode", 32'(mode_o_a), 1);
    chk("sethr.blink", 32'(blink_a), 1);
    rep(0, 3, 0, 1);
    step(0, 0, 1, 0);
    chk("setmin2.mode", 32'(mode_o_a), 2);
    chk("setmin2.blink", 32'(blink_a), 1);
    rep(0, 45, 0, 1);
    chk_time("edit", 13, 5, 45);
    step(0, 0, 1, 0);
    chk_time("exit", 13, 5, 0);
    chk("exit.mode", 32'(mode_o_a), 0);
    chk("exit.blink", 32'(blink_a), 0);
    step(0, 1, 0, 0);
    chk("resume.seconds", 32'(seconds_a), 1);
    step(0, 0, 0, 1);
    chk_time("run_inc_ignored", 13, 5, 1);

    // Blink toggling in SET_HR with time frozen
    step(0, 0, 1, 0);
    chk("blk0", 32'(blink_a), 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0);
      chk($sformatf("blk%0d", k + 1), 32'(blink_a), 32'((k + 1) % 2 == 0));
    end
    chk_time("frozen", 13, 5, 1);
    step(0, 1, 1, 0);
    chk("modetick.mode", 32'(mode_o_a), 2);
    chk("modetick.blink", 32'(blink_a), 1);
    step(0, 1, 0, 0);
    chk("setmin_tick.blink", 32'(blink_a), 0);
    step(0, 0, 1, 0);
    chk_time("exit2", 13, 5, 0);

    // Simultaneous mode_btn+tick at 01:59:59, then mode_btn+inc_btn
    step(0, 0, 1, 0);
    rep(0, 12, 0, 1);
    step(0, 0, 1, 0);
    rep(0, 54, 0, 1);
    step(0, 0, 1, 0);
    rep(0, 59, 1, 0);
    chk_time("t0159", 1, 59, 59);
    step(0, 1, 1, 0);
    chk_time("mt", 2, 0, 0);
    chk("mt.mode", 32'(mode_o_a), 1);
    chk("mt.blink", 32'(blink_a), 1);
    chk("mt.day_wrap", 32'(day_wrap_a), 0);
    step(0, 0, 1, 1);
    chk("mi.hours", 32'(hours_a), 3);
    chk("mi.mode", 32'(mode_o_a), 2);
    step(0, 0, 1, 1);
    chk("mi2.minutes", 32'(minutes_a), 1);
    chk("mi2.seconds", 32'(seconds_a), 0);
    chk("mi2.mode", 32'(mode_o_a), 0);

    // 12-hour instance: rollover and hour modulus
    step(1, 0, 1, 0);
    rep(1, 11, 0, 1);
    step(1, 0, 1, 0);
    rep(1, 59, 0, 1);
    step(1, 0, 1, 0);
    rep(1, 59, 1, 0);
    chk("h12.pre.hours", 32'(hours_b), 11);
    chk("h12.pre.seconds", 32'(seconds_b), 59);
    step(1, 1, 0, 0);
    chk("h12.wrap.hours", 32'(hours_b), 0);
    chk("h12.wrap.minutes", 32'(minutes_b), 0);
    chk("h12.wrap.seconds", 32'(seconds_b), 0);
    chk("h12.wrap.day_wrap", 32'(day_wrap_b), 1);
    step(1, 0, 1, 0);
    rep(1, 4, 0, 1);
    chk("h12.set4", 32'(hours_b), 4);
    rep(1, 12, 0, 1);
    chk("h12.full_lap", 32'(hours_b), 4);
    chk("h12.day_wrap_set", 32'(day_wrap_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
